xor_stream_decimator: RTL and testbench
=======================================

// Module: xor_stream_decimator
// PURPOSE
//  Consumes the decimated XOR/confidence/disparity pixel stream from the disparity-filtering stage.
//  Accumulates decimate_factor beats of decimate_factor XOR bits into one mismatch count per output pixel.
//  Buffers {mismatch count, confidence, disparity, sof, eol} in an internal FIFO.
//  Returns almost-full backpressure upstream; presents a valid/ready stream to the output packer.
// PARAMETERS
//  decimate_factor   2    XOR bits per beat and beats per output pixel (power of 2, >=2)
//  out_cols          120  output pixels per line (frame_w / decimate_factor)
//  out_rows          24   output lines per band (3*blk_h / decimate_factor)
//  fifo_depth        16   FIFO entries (power of 2)
//  af_margin         8    almost_full asserted when count >= fifo_depth - af_margin; must be >= decimate_factor*2+2
//  conf_thresh       32   min confidence kept (CONF_GATE_EN only)
//  mismatch_thresh   2    max mismatch count kept (CONF_GATE_EN only)
// PORTS
//  clk               in   1     clock
//  reset             in   1     synchronous, active-high reset
//  pix_stream_data   in   D     XOR bits for one beat (D = decimate_factor)
//  conf_in           in   8     block confidence, held constant across a pixel's beats
//  disp_in           in   8     block disparity, held constant across a pixel's beats
//  pix_stream_valid  in   1     beat valid; no ready, upstream obeys fifo_almost_full
//  fifo_almost_full  out  1     backpressure to upstream reader
//  out_valid         out  1     output pixel available
//  out_ready         in   1     consumer accepts when out_valid & out_ready
//  out_mismatch      out  MW    popcount over D*D bits, MW = $clog2(D*D+1)
//  out_conf          out  8     confidence
//  out_disp          out  8     disparity
//  out_sof           out  1     first pixel of band (col 0, row 0)
//  out_eol           out  1     last pixel of a line (col out_cols-1)
//  overflow          out  1     sticky: a pixel was dropped on a full FIFO
// BEHAVIOUR
//  Reset: beat_cnt=0, acc=0, col=0, row=0, FIFO empty.
//  Reset outputs: out_valid=0, fifo_almost_full=0, overflow=0, data outputs 0.
//  Reset mid-pixel discards any partial accumulation.
//  Accumulator:
//   - Each valid beat: acc += popcount(pix_stream_data), beat_cnt++.
//   - Beat D-1: push {acc+popcount, conf_in, disp_in, sof, eol} in the same cycle; acc and beat_cnt clear.
//   - Invalid cycles hold all state; gaps between beats are legal.
//  Position counters:
//   - col increments per pushed pixel, wraps at out_cols-1 with row++.
//   - row wraps at out_rows-1 to 0.
//   - sof = (col==0 && row==0); eol = (col==out_cols-1).
//  FIFO: show-ahead, registered outputs.
//   - Entry pushed at cycle N appears on out_* with out_valid=1 at N+1 if the FIFO was empty.
//   - Pop on out_valid & out_ready; the next entry is visible the following cycle.
//   - Simultaneous push+pop while full is accepted, count unchanged.
//   - Push while full without pop: entry dropped, overflow set until reset; counters still advance.
//   - Pop when empty: ignored.
//   - fifo_almost_full is registered: count >= fifo_depth - af_margin, from the post-update count.
//  Output data is stable while out_valid & !out_ready.
// CONFIGURATION
//  CONF_GATE_EN defined:
//   - At push, if conf_in < conf_thresh or mismatch > mismatch_thresh, stored disp=0 and conf=0.
//   - mismatch, sof and eol are stored unchanged.
//  CONF_GATE_EN undefined: conf/disp pass through unmodified; thresh params unused.
// TESTING
//  1. D=2; beats 2'b11,2'b01, conf=40, disp=7, out_ready=1
//     -> one pixel, mismatch=3, conf=40, disp=7, sof=1, out_valid one cycle after second beat.
//  2. 240 continuous valid beats of 2'b00
//     -> 120 pixels, mismatch=0, eol only on pixel 120; next band pixel has sof=1 after 24 lines.
//  3. out_ready=0, stream pixels
//     -> fifo_almost_full rises when count reaches 8; after 16 pixels a 17th is dropped, overflow=1.
//  4. FIFO full, out_ready=1 with simultaneous push
//     -> no drop, count stays 16, overflow stays 0.
//  5. Reset asserted after the first beat of a pixel, then beats 2'b10,2'b10
//     -> mismatch=2; no stale accumulation; outputs 0 during reset.
//  6. CONF_GATE_EN: conf=10, bits all 1
//     -> disp=0, conf=0, mismatch=4; without the macro -> disp/conf passed through.

Source files
------------

// File: rtl/xor_stream_decimator.sv
// rtl/xor_stream_decimator.sv - XOR popcount decimator with show-ahead output FIFO
// Optional: define CONF_GATE_EN to zero conf/disp of low-confidence or high-mismatch pixels.
module xor_stream_decimator #(
    parameter int decimate_factor = 2,
    parameter int out_cols        = 120,
    parameter int out_rows        = 24,
    parameter int fifo_depth      = 16,
    parameter int af_margin       = 8,
    parameter int conf_thresh     = 32,
    parameter int mismatch_thresh = 2
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic [decimate_factor-1:0]                            pix_stream_data,
    input  logic [7:0]                                            conf_in,
    input  logic [7:0]                                            disp_in,
    input  logic                                                  pix_stream_valid,
    output logic                                                  fifo_almost_full,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [$clog2(decimate_factor*decimate_factor+1)-1:0]  out_mismatch,
    output logic [7:0]                                            out_conf,
    output logic [7:0]                                            out_disp,
    output logic                                                  out_sof,
    output logic                                                  out_eol,
    output logic                                                  overflow
);
    localparam int MW = $clog2(decimate_factor*decimate_factor+1);
    localparam int BW = $clog2(decimate_factor);
    localparam int CW = $clog2(out_cols);
    localparam int RW = $clog2(out_rows);
    localparam int PW = $clog2(fifo_depth);
    localparam int EW = MW + 18;
`ifdef CONF_GATE_EN
    localparam bit GATE_EN = 1'b1;
`else
    localparam bit GATE_EN = 1'b0;
`endif

    function automatic logic [MW-1:0] popcount(input logic [decimate_factor-1:0] v);
        logic [MW-1:0] n;
        n = '0;
        for (int i = 0; i < decimate_factor; i++) begin
            n = n + MW'(v[i]);
        end
        return n;
    endfunction

    logic [BW-1:0] beat_cnt;
    logic [MW-1:0] acc;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [MW-1:0] pixel_sum;
    logic          push;
    logic          sof;
    logic          eol;
    logic          gate_hit;
    logic [7:0]    conf_st;
    logic [7:0]    disp_st;
    logic [EW-1:0] push_entry;

    assign pixel_sum  = acc + popcount(pix_stream_data);
    assign push       = pix_stream_valid && (beat_cnt == BW'(decimate_factor - 1));
    assign sof        = (col == '0) && (row == '0);
    assign eol        = (col == CW'(out_cols - 1));
    assign gate_hit   = (conf_in < 8'(conf_thresh)) || (pixel_sum > MW'(mismatch_thresh));
    assign conf_st    = (GATE_EN && gate_hit) ? 8'd0 : conf_in;
    assign disp_st    = (GATE_EN && gate_hit) ? 8'd0 : disp_in;
    assign push_entry = {pixel_sum, conf_st, disp_st, sof, eol};

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            acc      <= '0;
            col      <= '0;
            row      <= '0;
        end else if (pix_stream_valid) begin
            if (push) begin
                beat_cnt <= '0;
                acc      <= '0;
                // Position advances even when the FIFO drops the pixel, keeping framing aligned.
                if (eol) begin
                    col <= '0;
                    row <= (row == RW'(out_rows - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                acc      <= pixel_sum;
            end
        end
    end

    logic [EW-1:0] mem [fifo_depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic          pop;
    logic          push_ok;
    logic [PW:0]   count_after_pop;
    logic [PW:0]   count_next;
    logic [PW-1:0] rd_ptr_next;
    logic [EW-1:0] head_next;

    assign pop             = out_valid && out_ready;
    assign push_ok         = push && ((count != (PW+1)'(fifo_depth)) || pop);
    assign count_after_pop = count - (PW+1)'(pop);
    assign count_next      = count_after_pop + (PW+1)'(push_ok);
    assign rd_ptr_next     = rd_ptr + PW'(pop);
    // The output registers mirror the post-update head; an entry pushed into an
    // otherwise empty FIFO bypasses the memory read.
    assign head_next       = (count_after_pop == '0) ? push_entry : mem[rd_ptr_next];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            out_valid        <= 1'b0;
            fifo_almost_full <= 1'b0;
            overflow         <= 1'b0;
            out_mismatch     <= '0;
            out_conf         <= '0;
            out_disp         <= '0;
            out_sof          <= 1'b0;
            out_eol          <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            rd_ptr           <= rd_ptr_next;
            count            <= count_next;
            out_valid        <= (count_next != '0);
            fifo_almost_full <= (count_next >= (PW+1)'(fifo_depth - af_margin));
            if (count_next != '0) begin
                {out_mismatch, out_conf, out_disp, out_sof, out_eol} <= head_next;
            end
        end
    end
endmodule

// File: tb/tb_xor_stream_decimator.sv
// tb/tb_xor_stream_decimator.sv - directed self-checking bench for xor_stream_decimator
module tb_xor_stream_decimator;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] pix_stream_data;
    logic [7:0] conf_in;
    logic [7:0] disp_in;
    logic       pix_stream_valid;
    logic       fifo_almost_full;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_mismatch;
    logic [7:0] out_conf;
    logic [7:0] out_disp;
    logic       out_sof;
    logic       out_eol;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xor_stream_decimator dut (
        .clk              (clk),
        .reset            (reset),
        .pix_stream_data  (pix_stream_data),
        .conf_in          (conf_in),
        .disp_in          (disp_in),
        .pix_stream_valid (pix_stream_valid),
        .fifo_almost_full (fifo_almost_full),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_mismatch     (out_mismatch),
        .out_conf         (out_conf),
        .out_disp         (out_disp),
        .out_sof          (out_sof),
        .out_eol          (out_eol),
        .overflow         (overflow)
    );

    typedef struct {
        logic [1:0] b0;
        logic [1:0] b1;
        logic [7:0] conf;
        logic [7:0] disp;
        logic [2:0] mis;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [7:0] exp_cd(input logic [7:0] v, input logic [7:0] conf,
                                          input logic [2:0] mis);
`ifdef CONF_GATE_EN
        if (conf < 8'd32 || mis > 3'd2) return 8'd0;
`endif
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pix_stream_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic beat(input logic [1:0] d);
        pix_stream_data  = d;
        pix_stream_valid = 1'b1;
        tick();
        pix_stream_valid = 1'b0;
    endtask

    task automatic pixel(input logic [1:0] b0, input logic [1:0] b1,
                         input logic [7:0] c, input logic [7:0] d);
        conf_in = c;
        disp_in = d;
        beat(b0);
        beat(b1);
    endtask

    initial begin
        int n;
        vecs[0] = '{b0: 2'b11, b1: 2'b01, conf: 8'd40,  disp: 8'd7,  mis: 3'd3};
        vecs[1] = '{b0: 2'b00, b1: 2'b00, conf: 8'd200, disp: 8'd1,  mis: 3'd0};
        vecs[2] = '{b0: 2'b10, b1: 2'b01, conf: 8'd32,  disp: 8'd9,  mis: 3'd2};
        vecs[3] = '{b0: 2'b11, b1: 2'b11, conf: 8'd10,  disp: 8'd55, mis: 3'd4};
        vecs[4] = '{b0: 2'b01, b1: 2'b00, conf: 8'd31,  disp: 8'd3,  mis: 3'd1};

        pix_stream_data = 2'b00;
        conf_in = 8'd0;
        disp_in = 8'd0;
        out_ready = 1'b1;
        do_reset();
        check("reset_valid", out_valid, 0);
        check("reset_af", fifo_almost_full, 0);
        check("reset_overflow", overflow, 0);
        check("reset_mismatch", out_mismatch, 0);

        conf_in = vecs[0].conf;
        disp_in = vecs[0].disp;
        beat(vecs[0].b0);
        check("first_beat_no_valid", out_valid, 0);
        beat(vecs[0].b1);
        check("t1_valid", out_valid, 1);
        check("t1_mismatch", out_mismatch, 3);
        check("t1_sof", out_sof, 1);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            pixel(vecs[i].b0, vecs[i].b1, vecs[i].conf, vecs[i].disp);
            check("vec_valid", out_valid, 1);
            check("vec_mismatch", out_mismatch, vecs[i].mis);
            check("vec_conf", out_conf, exp_cd(vecs[i].conf, vecs[i].conf, vecs[i].mis));
            check("vec_disp", out_disp, exp_cd(vecs[i].disp, vecs[i].conf, vecs[i].mis));
            check("vec_sof", out_sof, (i == 0) ? 1 : 0);
        end

        do_reset();
        for (int r = 0; r < 24; r++) begin
            for (int c = 0; c < 120; c++) begin
                pixel(2'b00, 2'b00, 8'd100, 8'd5);
                check("band_valid", out_valid, 1);
                check("band_eol", out_eol, (c == 119) ? 1 : 0);
                check("band_sof", out_sof, (c == 0 && r == 0) ? 1 : 0);
            end
        end
        pixel(2'b00, 2'b00, 8'd100, 8'd5);
        check("band_wrap_sof", out_sof, 1);
        check("band_wrap_mismatch", out_mismatch, 0);

        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            pixel(2'(k), 2'b00, 8'd100, 8'(k));
            check("fill_af", fifo_almost_full, (k >= 8) ? 1 : 0);
            check("fill_overflow", overflow, (k >= 17) ? 1 : 0);
            check("fill_head_stable", out_disp, 1);
        end

        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            pixel(2'b00, 2'b00, 8'd100, 8'(k));
        end
        check("full_af", fifo_almost_full, 1);
        conf_in = 8'd100;
        disp_in = 8'd16;
        beat(2'b00);
        out_ready = 1'b1;
        beat(2'b00);
        check("pushpop_overflow", overflow, 0);
        n = 0;
        while (out_valid && n < 40) begin
            check("drain_order", out_disp, n + 1);
            n++;
            tick();
        end
        check("drain_count", n, 16);
        check("drain_overflow", overflow, 0);

        do_reset();
        out_ready = 1'b1;
        conf_in = 8'd50;
        disp_in = 8'd4;
        beat(2'b11);
        reset = 1'b1;
        tick();
        check("midreset_valid", out_valid, 0);
        check("midreset_mismatch", out_mismatch, 0);
        check("midreset_disp", out_disp, 0);
        reset = 1'b0;
        pixel(2'b10, 2'b10, 8'd50, 8'd4);
        check("midreset_after_valid", out_valid, 1);
        check("midreset_after_mismatch", out_mismatch, 2);
        check("midreset_after_sof", out_sof, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
